// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
// The state encoding is fixed so waveforms decode identically across tools.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic [3:0] STRB_NONE      = 4'b0000;
    localparam int         STARVE_MAX_DEF = 4;
    localparam int         TIMEOUT_DEF    = 64;
    localparam int         STARVE_W       = 4;
    localparam int         WAIT_W         = 8;

    // Saturating increment used by the fetch starvation guard.
    function automatic logic [STARVE_W-1:0] sat_inc(
        input logic [STARVE_W-1:0] value,
        input logic [STARVE_W-1:0] limit
    );
        return (value >= limit) ? limit : value + STARVE_W'(1);
    endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Loadable wait counter; tc flags the last cycle a memory access may wait
// before the arbiter aborts it.
module arb_timeout_ctr
    import mem_arb_pkg::*;
#(
    parameter int WIDTH    = WAIT_W,
    parameter int TERMINAL = TIMEOUT_DEF - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign tc = (count_reg == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// the data port: data first, bounded fetch starvation, timeout to bus error.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [3:0]        dm_wstrb,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_t          state_reg, state_next;
    logic                mem_req_reg, mem_req_next;
    logic                mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
    logic [3:0]          mem_wstrb_reg, mem_wstrb_next;
    logic [DATA_W-1:0]   if_rdata_reg, if_rdata_next;
    logic [DATA_W-1:0]   dm_rdata_reg, dm_rdata_next;
    logic                if_ready_reg, if_ready_next;
    logic                dm_ready_reg, dm_ready_next;
    logic                bus_err_reg, bus_err_next;
    logic [STARVE_W-1:0] starve_reg, starve_next;
    logic                ctr_load, ctr_en, wait_tc;
    logic [3:0]          dm_strb_eff;

    // Loads never drive byte strobes onto the memory bus.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_strb
            assign dm_strb_eff[gi] = dm_we & dm_wstrb[gi];
        end
    endgenerate

    arb_timeout_ctr #(
        .WIDTH    (WAIT_W),
        .TERMINAL (TIMEOUT - 1)
    ) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val ('0),
        .en       (ctr_en),
        .tc       (wait_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= STRB_NONE;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
            if_ready_reg  <= 1'b0;
            dm_ready_reg  <= 1'b0;
            bus_err_reg   <= 1'b0;
            starve_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wstrb_reg <= mem_wstrb_next;
            if_rdata_reg  <= if_rdata_next;
            dm_rdata_reg  <= dm_rdata_next;
            if_ready_reg  <= if_ready_next;
            dm_ready_reg  <= dm_ready_next;
            bus_err_reg   <= bus_err_next;
            starve_reg    <= starve_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wstrb_next = mem_wstrb_reg;
        if_rdata_next  = if_rdata_reg;
        dm_rdata_next  = dm_rdata_reg;
        if_ready_next  = 1'b0;
        dm_ready_next  = 1'b0;
        bus_err_next   = 1'b0;
        starve_next    = starve_reg;
        ctr_load       = 1'b0;
        ctr_en         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (dm_req && !(if_req && starve_reg == STARVE_LIM)) begin
                    state_next     = GNT_DM;
                    mem_req_next   = 1'b1;
                    mem_we_next    = dm_we;
                    mem_addr_next  = dm_addr;
                    mem_wdata_next = dm_wdata;
                    mem_wstrb_next = dm_strb_eff;
                    starve_next    = if_req ? sat_inc(starve_reg, STARVE_LIM) : '0;
                    ctr_load       = 1'b1;
                end else if (if_req) begin
                    state_next     = GNT_IF;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = if_addr;
                    mem_wstrb_next = STRB_NONE;
                    starve_next    = '0;
                    ctr_load       = 1'b1;
                end
            end
            GNT_IF, GNT_DM: begin
                // An ack in the terminal cycle still counts as a normal completion.
                if (mem_ack || wait_tc) begin
                    state_next   = RESP;
                    mem_req_next = 1'b0;
                    bus_err_next = !mem_ack;
                    ctr_load     = 1'b1;
                    if (state_reg == GNT_IF) begin
                        if_ready_next = 1'b1;
                        if_rdata_next = mem_ack ? mem_rdata : '0;
                    end else begin
                        dm_ready_next = 1'b1;
                        dm_rdata_next = mem_ack ? mem_rdata : '0;
                    end
                end else begin
                    ctr_en = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign if_ready  = if_ready_reg;
    assign dm_ready  = dm_ready_reg;
    assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic [3:0]        dm_wstrb = 4'b0000;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              bus_err;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_wstrb  (dm_wstrb),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after mem_wait extra cycles, data = address + 3.
    int mem_wait = 0;
    int mem_cnt = 0;
    bit mem_mute = 1'b0;
    bit stray_ack = 1'b0;

    always begin
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        if (stray_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0_BAD0;
            stray_ack = 1'b0;
            mem_cnt   = 0;
        end else if (mem_req && !mem_mute) begin
            if (mem_cnt >= mem_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr + 32'h3;
                mem_cnt   = 0;
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // Transaction-level model: owner of the access in flight, cycles waited,
    // one response cycle, and the starvation count of consecutive data wins.
    int          m_owner = 0;   // 0 none, 1 fetch, 2 data
    bit          m_resp = 1'b0;
    int          m_wait = 0;
    int          m_starve = 0;
    logic        e_mem_req = 1'b0, e_mem_we = 1'b0;
    logic        e_if_ready = 1'b0, e_dm_ready = 1'b0, e_bus_err = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_if_rdata = '0, e_dm_rdata = '0, m_d;
    logic [3:0]  e_strb = 4'b0000;
    logic [31:0] m_grants[$];

    always @(posedge clk) begin
        if (reset) begin
            m_owner = 0; m_resp = 1'b0; m_wait = 0; m_starve = 0;
            e_mem_req = 1'b0; e_mem_we = 1'b0; e_addr = '0; e_wdata = '0; e_strb = 4'b0000;
            e_if_ready = 1'b0; e_dm_ready = 1'b0; e_bus_err = 1'b0;
            e_if_rdata = '0; e_dm_rdata = '0;
        end else begin
            e_if_ready = 1'b0; e_dm_ready = 1'b0; e_bus_err = 1'b0;
            if (m_resp) begin
                m_resp = 1'b0;
            end else if (m_owner != 0) begin
                if (mem_ack || m_wait == TIMEOUT - 1) begin
                    m_d = mem_ack ? mem_rdata : 32'h0;
                    e_bus_err = !mem_ack;
                    if (m_owner == 1) begin e_if_ready = 1'b1; e_if_rdata = m_d; end
                    else              begin e_dm_ready = 1'b1; e_dm_rdata = m_d; end
                    e_mem_req = 1'b0; m_owner = 0; m_resp = 1'b1; m_wait = 0;
                end else begin
                    m_wait++;
                end
            end else if (dm_req && !(if_req && m_starve == STARVE_MAX)) begin
                m_owner = 2; e_mem_req = 1'b1; m_wait = 0;
                e_mem_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata;
                e_strb = dm_we ? dm_wstrb : 4'b0000;
                m_starve = if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
                m_grants.push_back(dm_addr);
            end else if (if_req) begin
                m_owner = 1; e_mem_req = 1'b1; m_wait = 0;
                e_mem_we = 1'b0; e_addr = if_addr; e_strb = 4'b0000;
                m_starve = 0;
                m_grants.push_back(if_addr);
            end
        end
    end

    // Per-cycle compare against the model, plus activity tallies for scenarios.
    bit          cmp_on = 1'b0;
    logic        prev_mem_req = 1'b0;
    int          n_mem_req = 0, n_if_rdy = 0, n_dm_rdy = 0, n_err = 0;
    logic [31:0] dut_grants[$];

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("mem_req", mem_req, e_mem_req);
            chk("mem_we", mem_we, e_mem_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wstrb", mem_wstrb, e_strb);
            chk("if_ready", if_ready, e_if_ready);
            chk("dm_ready", dm_ready, e_dm_ready);
            chk("bus_err", bus_err, e_bus_err);
            if (e_if_ready) chk("if_rdata", if_rdata, e_if_rdata);
            if (e_dm_ready) chk("dm_rdata", dm_rdata, e_dm_rdata);
            if (e_mem_req && m_owner == 2) chk("mem_wdata", mem_wdata, e_wdata);
            chk("one_hot", $countones({mem_req, if_ready, dm_ready}) <= 1, 1);
            if (mem_req && !prev_mem_req) dut_grants.push_back(mem_addr);
            prev_mem_req = mem_req;
            n_mem_req += int'(mem_req);
            n_if_rdy  += int'(if_ready);
            n_dm_rdy  += int'(dm_ready);
            n_err     += int'(bus_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(input bit is_dm, input int budget, input string name);
        int k = 0;
        while (!(is_dm ? dm_ready : if_ready)) begin
            if (k == budget) begin
                checks++;
                errors++;
                $display("FAIL %s: ready not seen, got none within %0d cycles", name, budget);
                return;
            end
            tick(1);
            k++;
        end
    endtask

    logic [31:0] exp_order [10] = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h200,
                                    32'h300, 32'h300, 32'h300, 32'h300, 32'h200};

    initial begin
        int k;
        tick(2);
        cmp_on = 1'b1;
        tick(1);
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wstrb", mem_wstrb, 0);
        chk("rst if_rdata", if_rdata, 0);
        chk("rst dm_rdata", dm_rdata, 0);
        chk("rst readies", {if_ready, dm_ready, bus_err}, 0);
        reset = 1'b0;
        tick(2);

        // Single zero-wait fetch.
        $display("txn fetch addr=0x10 zero-wait");
        mem_wait = 0; if_addr = 32'h10; if_req = 1'b1;
        tick(1);
        chk("t1 mem_req c1", mem_req, 1);
        chk("t1 mem_addr c1", mem_addr, 32'h10);
        tick(1);
        chk("t1 if_ready c2", if_ready, 1);
        chk("t1 if_rdata c2", if_rdata, 32'h13);
        chk("t1 no grant c2", mem_req, 0);
        if_req = 1'b0;
        tick(1);
        chk("t1 ready single", if_ready, 0);
        tick(2);

        // Store with three wait cycles.
        $display("txn store addr=0x100 data=deadbeef strb=0011 wait=3");
        mem_wait = 3; n_mem_req = 0; n_dm_rdy = 0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_wstrb = 4'b0011;
        tick(1);
        chk("t2 mem_wstrb", mem_wstrb, 4'b0011);
        chk("t2 mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t2 mem_we", mem_we, 1);
        wait_ready(1'b1, 20, "t2 dm_ready");
        dm_req = 1'b0; dm_we = 1'b0;
        tick(3);
        chk("t2 mem_req cycles", n_mem_req, 4);
        chk("t2 dm_ready pulses", n_dm_rdy, 1);

        // Contention with both requests held.
        $display("txn contention fetch=0x200 load=0x300");
        mem_wait = 0; dut_grants.delete(); m_grants.delete();
        if_addr = 32'h200; dm_addr = 32'h300; dm_we = 1'b0; dm_wstrb = 4'hF;
        if_req = 1'b1; dm_req = 1'b1;
        k = 0;
        while (dut_grants.size() < 10 && k < 60) begin
            tick(1);
            k++;
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick(6);
        chk("t3 dut grant count", dut_grants.size(), 10);
        chk("t3 model grant count", m_grants.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < dut_grants.size()) chk($sformatf("t3 dut grant %0d", i), dut_grants[i], exp_order[i]);
            if (i < m_grants.size())   chk($sformatf("t3 model grant %0d", i), m_grants[i], exp_order[i]);
        end

        // Load that never gets an ack, then a stray ack.
        $display("txn load addr=0x40 timeout");
        mem_mute = 1'b1; n_mem_req = 0; n_dm_rdy = 0; n_if_rdy = 0; n_err = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        wait_ready(1'b1, 100, "t4 dm_ready");
        chk("t4 bus_err", bus_err, 1);
        chk("t4 dm_rdata", dm_rdata, 0);
        chk("t4 mem_req cycles", n_mem_req, TIMEOUT);
        dm_req = 1'b0;
        tick(2);
        stray_ack = 1'b1;
        tick(4);
        mem_mute = 1'b0;
        chk("t4 dm_ready pulses", n_dm_rdy, 1);
        chk("t4 bus_err pulses", n_err, 1);
        chk("t4 if_ready pulses", n_if_rdy, 0);

        // Reset during the second wait cycle of a fetch.
        $display("txn fetch addr=0x80 reset mid-access");
        mem_mute = 1'b1; if_addr = 32'h80; if_req = 1'b1;
        tick(2);
        chk("t5 mem_req before reset", mem_req, 1);
        reset = 1'b1;
        tick(1);
        chk("t5 mem_req after reset", mem_req, 0);
        chk("t5 mem_addr after reset", mem_addr, 0);
        reset = 1'b0; if_req = 1'b0; mem_mute = 1'b0;
        tick(2);
        $display("txn fetch addr=0x84 after reset");
        if_addr = 32'h84; if_req = 1'b1;
        wait_ready(1'b0, 10, "t5 if_ready");
        chk("t5 if_rdata", if_rdata, 32'h87);
        if_req = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF-stage instruction fetch port and the MEM-stage data port of the 5-stage RV32I pipeline.
- Sequences each access as a request/acknowledge transaction and returns a registered one-cycle ready pulse to the winning requester.
- Gives priority to data, with a starvation guard for fetch and a timeout that converts a hung memory access into a bus error.
- Sits between cpu_top's pipeline stages and the memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32.
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending; range 1..15.
- TIMEOUT, 64, maximum cycles waiting for mem_ack before aborting; range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with stable if_addr until if_ready.
- if_addr  in  ADDR_W  fetch byte address; word aligned.
- if_rdata  out  DATA_W  fetched word; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for a fetch.
- dm_req  in  1  data request; held with stable fields until dm_ready.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  DATA_W  store data.
- dm_wstrb  in  4  store byte enables.
- dm_rdata  out  DATA_W  load data; valid while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for a data access.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wstrb  out  4  byte strobes; 0000 for reads.
- mem_ack  in  1  memory completion, one cycle; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- bus_err  out  1  one-cycle pulse coincident with a ready that timed out.

Behaviour:
- State machine: IDLE, GNT_IF, GNT_DM, RESP.
- All outputs are registered. Reset values:
  - state=IDLE
  - mem_req, mem_we, if_ready, dm_ready, bus_err = 0
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0; mem_wstrb = 0000
  - starve_cnt=0, wait_cnt=0
- IDLE, no request pending: stay in IDLE with all outputs quiescent.
- IDLE, arbitration:
  - If dm_req=1 and not (if_req=1 and starve_cnt==STARVE_MAX): go to GNT_DM. Latch dm fields onto mem_*. mem_wstrb = dm_we ? dm_wstrb : 0000. Set mem_req=1.
  - Else if if_req=1: go to GNT_IF. Latch if_addr. mem_we=0, mem_wstrb=0000, mem_req=1.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each DM grant made while if_req=1.
  - Clears on each IF grant.
  - Clears on a DM grant made while if_req=0.
- GNT_x, no ack: hold every mem_* output stable and increment wait_cnt.
- GNT_x, mem_ack=1:
  - Drop mem_req.
  - Capture mem_rdata into if_rdata or dm_rdata.
  - Assert the matching ready for the next cycle; go to RESP; clear wait_cnt.
- GNT_x, timeout (wait_cnt==TIMEOUT-1 with no ack):
  - Drop mem_req.
  - Return rdata=0 with the matching ready and bus_err=1 for one cycle; go to RESP.
  - A later stray mem_ack is ignored.
- RESP: exactly one cycle. No grant is made in RESP, because the requester still holds its req in this cycle. The ready pulse is deasserted on exit; return to IDLE.
- Latency with zero-wait memory (ack in first mem_req cycle): req sampled in cycle 0 → mem_req in cycle 1 → ready in cycle 2. Throughput is one access per 3 cycles. Each memory wait cycle adds one cycle.
- Exactly one of mem_req, if_ready, dm_ready may be high in any cycle.
- Requester deasserting req while its access is granted (pipeline flush): the access still completes and ready still pulses; the requester ignores it. The arbiter never cancels mid-transaction.
- Reset asserted mid-transaction: at that edge, return to IDLE and drop mem_req; counters clear. Memory must tolerate an abandoned request.
- Simultaneous if_req and dm_req with starve_cnt<STARVE_MAX: data wins.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding localparams (IDLE=2'd0, GNT_IF=2'd1, GNT_DM=2'd2, RESP=2'd3)
  - STRB_NONE=4'b0000
  - default STARVE_MAX and TIMEOUT.
- One natural sub-module, arb_timeout_ctr: loadable wait counter with a terminal-count flag. Everything else stays flat.

Test Plan:
- Single fetch with zero-wait memory: if_req=1, if_addr=0x0000_0010, mem_ack in the first mem_req cycle with mem_rdata=0x0000_0013 → mem_addr=0x10 and mem_req in cycle 1; if_ready=1 and if_rdata=0x13 in cycle 2; nothing granted in cycle 2.
- Store: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_wstrb=0011, with 3 wait cycles → mem_* stable for 4 cycles; mem_wstrb=0011; dm_ready pulses once, 1 cycle after ack.
- Contention: if_req and dm_req held continuously with STARVE_MAX=4 → grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF; starve_cnt resets after each IF grant.
- Timeout: dm_req load, mem_ack never asserted, TIMEOUT=64 → mem_req high for 64 cycles; next cycle dm_ready=1, dm_rdata=0, bus_err=1; a later ack causes no ready.
- Reset mid-access: assert reset during GNT_IF wait cycle 2 → next cycle mem_req=0 and state IDLE; after release, a fresh if_req completes normally.
